// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter for the five PWM/output config registers
module reg_bank_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [ADDR_W-1:0]    req0_addr,
    input  logic [DATA_W-1:0]    req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [ADDR_W-1:0]    req1_addr,
    input  logic [DATA_W-1:0]    req1_data,
    output logic                 req1_ready,
    output logic [DATA_W-1:0]    en_reg_out_7_0,
    output logic [DATA_W-1:0]    en_reg_out_15_8,
    output logic [DATA_W-1:0]    en_reg_pwm_7_0,
    output logic [DATA_W-1:0]    en_reg_pwm_15_8,
    output logic [DATA_W-1:0]    pwm_duty_cycle,
    output logic                 err_addr,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 last_grant
);
    localparam int NREG = 5;
    localparam logic [ADDR_W-1:0] NREG_A = ADDR_W'(NREG);
    logic [DATA_W-1:0]    regs_q [NREG];
    logic [DATA_W-1:0]    regs_d [NREG];
    logic                 err_q, err_d, lg_q, lg_d, gnt0, xfer, hit;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_data;
    always_comb begin
        // lg_q=1 means requester 1 went last, so requester 0 wins a tie
        gnt0       = req0_valid && (!req1_valid || lg_q);
        req0_ready = !rst && gnt0;
        req1_ready = !rst && req1_valid && !gnt0;
        xfer       = req0_ready || req1_ready;
        w_addr     = req1_ready ? req1_addr : req0_addr;
        w_data     = req1_ready ? req1_data : req0_data;
        hit        = w_addr < NREG_A;
        for (int i = 0; i < NREG; i++)
            regs_d[i] = (xfer && hit && w_addr == ADDR_W'(i)) ? w_data : regs_q[i];
        err_d = xfer && !hit;
        cnt_d = (err_d && cnt_q != '1) ? cnt_q + ERR_CNT_W'(1) : cnt_q;
        lg_d  = xfer ? req1_ready : lg_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
            lg_q  <= 1'b1;
        end else begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= regs_d[i];
            err_q <= err_d;
            cnt_q <= cnt_d;
            lg_q  <= lg_d;
        end
    end
    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign err_addr        = err_q;
    assign err_count       = cnt_q;
    assign last_grant      = lg_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [6:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic [7:0] r0, r1, r2, r3, r4, err_count;
    logic       err_addr, last_grant;
    int         total = 0;
    int         bad = 0;
    int         g0, g1;

    reg_bank_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2), .en_reg_pwm_15_8(r3),
        .pwm_duty_cycle(r4), .err_addr(err_addr), .err_count(err_count), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [39:0] exp);
        check(tag, {r4, r3, r2, r1, r0}, exp);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
        // 1: reset then single write
        tick(); tick();
        req0_valid = 1; req1_valid = 1; #1;
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check_regs("rst_regs", 40'h0);
        check("rst_cnt", err_count, 0);
        check("rst_err", err_addr, 0);
        check("rst_lg", last_grant, 1);
        req1_valid = 0; req0_addr = 4; req0_data = 8'h80;
        rst = 0; #1;
        check("w1_ready", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 0;
        check("w1_duty", r4, 8'h80);
        check("w1_lg", last_grant, 0);
        // 2: tie, last_grant=0 here so req1 then req0
        req0_valid = 1; req0_addr = 0; req0_data = 8'h11;
        req1_valid = 1; req1_addr = 1; req1_data = 8'h22; #1;
        check("tie_c1", {req0_ready, req1_ready}, 2'b01);
        tick();
        req1_valid = 0; #1;
        check("tie_c2", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 0;
        check_regs("tie_regs", 40'h80_00_00_22_11);
        check("tie_lg", last_grant, 0);
        // make last_grant=1 for the spec's tie scenario
        req1_valid = 1; req1_addr = 1; req1_data = 8'h22;
        tick();
        req1_valid = 0;
        check("tie_lg1", last_grant, 1);
        req0_valid = 1; req0_addr = 0; req0_data = 8'h11;
        req1_valid = 1; req1_addr = 1; req1_data = 8'h22; #1;
        check("tie2_c1", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 0; #1;
        check("tie2_c2", {req0_ready, req1_ready}, 2'b01);
        tick();
        req1_valid = 0;
        check("tie2_lg", last_grant, 1);
        // 3: same-address contention
        req0_valid = 1; req0_addr = 2; req0_data = 8'hAA;
        req1_valid = 1; req1_addr = 2; req1_data = 8'h55; #1;
        check("same_c1", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 0;
        check("same_mid", r2, 8'hAA);
        check("same_c2", {req0_ready, req1_ready}, 2'b01);
        tick();
        req1_valid = 0;
        check("same_final", r2, 8'h55);
        check("same_lg", last_grant, 1);
        // 4: unmapped write
        req1_valid = 1; req1_addr = 5; req1_data = 8'hFF; #1;
        check("unm_ready", req1_ready, 1);
        check("unm_err_pre", err_addr, 0);
        tick();
        req1_valid = 0;
        check("unm_err", err_addr, 1);
        check("unm_cnt", err_count, 1);
        check_regs("unm_regs", 40'h80_00_55_22_11);
        tick();
        check("unm_err_off", err_addr, 0);
        req1_valid = 1; req1_addr = 7'd127;
        for (int i = 0; i < 300; i++) tick();
        check("sat_err", err_addr, 1);
        check("sat_cnt", err_count, 8'd255);
        req1_valid = 0;
        tick();
        check("sat_err_off", err_addr, 0);
        check("sat_hold", err_count, 8'd255);
        check_regs("sat_regs", 40'h80_00_55_22_11);
        // 5: fairness, last_grant=1 so req0 first
        req0_valid = 1; req0_addr = 0; req0_data = 8'h5A;
        req1_valid = 1; req1_addr = 1; req1_data = 8'hA5;
        g0 = 0; g1 = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("fair_pat", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            g0 += int'(req0_ready);
            g1 += int'(req1_ready);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        check("fair_g0", g0, 5);
        check("fair_g1", g1, 5);
        check_regs("fair_regs", 40'h80_00_55_A5_5A);
        check("fair_lg", last_grant, 1);
        // 6: reset mid-request
        req0_valid = 1; req0_addr = 3; req0_data = 8'h3C;
        rst = 1; #1;
        check("rmid_ready", req0_ready, 0);
        tick();
        check_regs("rmid_regs", 40'h0);
        rst = 0; #1;
        check("rmid_rel", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 0;
        check("rmid_w", r3, 8'h3C);
        check("rmid_lg", last_grant, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Owns the five PWM/output configuration registers and shares write access to them between two requesters.
- Requester 0 is the SPI frame path; requester 1 is the on-chip local/test write port.
- Arbitration is round-robin, one register write per clk cycle, with a valid/ready handshake per requester.
- Decodes addresses, drops writes to unmapped addresses, and keeps a saturating error count.

Parameters:
ADDR_W, 7, register address width
DATA_W, 8, register data width
ERR_CNT_W, 8, width of the saturating invalid-address counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 (SPI) write request
req0_addr  input  ADDR_W  requester 0 target address
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 write accepted this cycle
req1_valid  input  1  requester 1 (local) write request
req1_addr  input  ADDR_W  requester 1 target address
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 write accepted this cycle
en_reg_out_7_0  output  DATA_W  register at address 0
en_reg_out_15_8  output  DATA_W  register at address 1
en_reg_pwm_7_0  output  DATA_W  register at address 2
en_reg_pwm_15_8  output  DATA_W  register at address 3
pwm_duty_cycle  output  DATA_W  register at address 4
err_addr  output  1  one-cycle pulse: accepted write had an unmapped address
err_count  output  ERR_CNT_W  saturating count of unmapped writes
last_grant  output  1  index of the most recently granted requester

Behaviour:
- Reset: while rst=1 at a clk edge, all five registers, err_addr and err_count go to 0, and last_grant goes to 1, so requester 0 wins the first tie.
- Ready gating: req0_ready and req1_ready are 0 whenever rst=1.
- Handshake: a transfer occurs in any cycle where valid=1 and ready=1.
  - A requester holds valid, addr and data stable until it sees ready.
  - valid must not depend on ready.
  - Dropping valid before ready is legal; the request is simply withdrawn, with no side effects.
- Ready is combinational from the valid inputs and last_grant, with no added latency. At most one ready is high per cycle.
- Grant rules (one-state round-robin, encoded in last_grant):
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester that is NOT last_grant.
  - Neither valid: no grant, last_grant unchanged.
- last_grant updates to the granted index on the clk edge of the transfer.
- Write latency: the addressed register holds the new value from the clk edge that ends the handshake cycle, i.e. it is visible one cycle after the handshake.
- Address decode: addresses 0–4 map to the registers in the order listed under Ports. Addresses 5–127 are unmapped.
- Unmapped write:
  - The handshake still completes (ready given) and the register bank is unchanged.
  - err_addr=1 for exactly one cycle after the edge.
  - err_count increments by 1, holding at 2^ERR_CNT_W-1 (255 by default) once reached.
  - last_grant updates as for a normal grant.
- err_addr is 0 in every cycle with no unmapped write. Back-to-back unmapped writes hold err_addr high on consecutive cycles.
- Same-address contention (both requesters target the same register in the same cycle):
  - Only the granted write lands.
  - The other requester keeps valid and lands on the next cycle, so the final value is the second-granted requester's data.
- Sustained contention: grants strictly alternate 0,1,0,1…; no starvation. Worst-case wait is 1 cycle.
- Reset mid-operation:
  - A request pending at reset is not accepted and is not written.
  - After rst falls, a still-asserted request is arbitrated normally, with requester 0 first on a tie.
- Registers are write-only through this block; there is no read path.

Test Plan:
1. Reset and single write: assert rst for 2 cycles, then check all registers=0, err_count=0 and both readies=0 during reset. Then req0 writes addr 4 data 0x80 → req0_ready=1 in the same cycle and pwm_duty_cycle=0x80 the next cycle.
2. Tie after reset: req0 (addr 0, 0x11) and req1 (addr 1, 0x22) valid together → cycle 1 grants req0 and cycle 2 grants req1; en_reg_out_7_0=0x11, en_reg_out_15_8=0x22, last_grant=1.
3. Same-address contention: both requesters target addr 2 (req0 0xAA, req1 0x55) with last_grant=1 → req0 lands first, then req1, leaving final en_reg_pwm_7_0=0x55.
4. Unmapped address: req1 writes addr 5 data 0xFF → handshake completes, all registers unchanged, err_addr pulses for 1 cycle, err_count=1. Then 300 back-to-back unmapped writes → err_count saturates at 255.
5. Fairness: both valid continuously for 10 cycles → ready pattern alternates 0,1,0,1…, with each requester granted exactly 5 times.
6. Reset mid-request: req0 valid with addr 3 data 0x3C, rst=1 the same cycle → no write and ready=0. Release rst with req0 still valid → en_reg_pwm_15_8=0x3C one cycle after the grant.
